// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends one external 8-bit T-flip-flop
// counter for a timed interval of len increments, then pulses done.
module counter_arbiter (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] cnt_q,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic       cnt_t,
  output logic       cnt_clr
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] len_r, len_nx;
  logic          sel, sel_nx;
  logic          last, last_nx;
  logic          gnt0_nx, gnt1_nx;
  logic          done0_nx, done1_nx;
  logic          busy_nx;
  logic          cnt_clr_nx;
  logic          req_sel;

  // Level request of whichever requester currently owns the counter
  assign req_sel = sel ? req1 : req0;

  // Toggle enable must follow the live counter so counting stops exactly at len_r
  assign cnt_t = (state == RUN) && (cnt_q != len_r);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      len_r   <= '0;
      sel     <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state   <= state_nx;
      len_r   <= len_nx;
      sel     <= sel_nx;
      last    <= last_nx;
      gnt0    <= gnt0_nx;
      gnt1    <= gnt1_nx;
      done0   <= done0_nx;
      done1   <= done1_nx;
      busy    <= busy_nx;
      cnt_clr <= cnt_clr_nx;
    end
  end

  // Next state plus the next value of every registered output
  always_comb begin
    state_nx   = state;
    len_nx     = len_r;
    sel_nx     = sel;
    last_nx    = last;
    gnt0_nx    = gnt0;
    gnt1_nx    = gnt1;
    done0_nx   = 1'b0;
    done1_nx   = 1'b0;
    cnt_clr_nx = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel_nx     = (req0 && req1) ? ~last : req1;
          len_nx     = sel_nx ? len1 : len0;
          gnt0_nx    = ~sel_nx;
          gnt1_nx    = sel_nx;
          cnt_clr_nx = 1'b1;
          state_nx   = CLEAR;
        end
      end
      CLEAR: state_nx = req_sel ? RUN : ABORT;
      RUN: begin
        if (!req_sel) begin
          state_nx = ABORT;
        end else if (cnt_q == len_r) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        state_nx = IDLE;
      end
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Entry actions: abort drops the grant and re-clears, done pulses once
    if (state_nx == ABORT) begin
      gnt0_nx    = 1'b0;
      gnt1_nx    = 1'b0;
      cnt_clr_nx = 1'b1;
      last_nx    = sel;
    end else if (state_nx == DONE) begin
      done0_nx = ~sel;
      done1_nx = sel;
      last_nx  = sel;
    end

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: external T-counter, timing-rule model checked every
// cycle, and directed scenarios with hand-computed cycle numbers.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       clr;
  logic       req0, req1;
  logic [7:0] len0, len1;
  logic [7:0] cnt_q;
  logic       gnt0, gnt1, done0, done1, busy, cnt_t, cnt_clr;

  always #5 clk = ~clk;

  // External toggle counter with asynchronous clear
  always_ff @(posedge clk or posedge cnt_clr) begin
    if (cnt_clr)    cnt_q <= 8'd0;
    else if (cnt_t) cnt_q <= cnt_q + 8'd1;
  end

  counter_arbiter dut (
    .clk     (clk),
    .clr     (clr),
    .req0    (req0),
    .req1    (req1),
    .len0    (len0),
    .len1    (len1),
    .cnt_q   (cnt_q),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .busy    (busy),
    .cnt_t   (cnt_t),
    .cnt_clr (cnt_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: one active interval described by its grant edge, length and abort edge
  bit m_act  = 1'b0;
  bit m_who  = 1'b0;
  bit m_last = 1'b1;
  int m_n    = 0;
  int m_len  = 0;
  int m_ab   = -1;

  // Event record used by the directed checks
  int order[$];
  int fg0, fg1, lg0, lg1, fd0, fd1, nd, tcnt, q_done;
  bit pg0 = 1'b0;
  bit pg1 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc + 1);
    end
  endtask

  task automatic clear_rec();
    order.delete();
    fg0 = 0; fg1 = 0; lg0 = 0; lg1 = 0; fd0 = 0; fd1 = 0;
    nd = 0; tcnt = 0; q_done = 0;
  endtask

  // One clock: step the model on the rising edge, compare on the falling edge
  task automatic tick();
    int c, k, e_g0, e_g1, e_d0, e_d1, e_busy, e_t, e_clr, q_exp;
    bit q_chk;
    @(posedge clk);
    cyc++;
    if (clr) begin
      m_act  = 1'b0;
      m_last = 1'b1;
    end else begin
      if (m_act) begin
        if (m_ab < 0 && (cyc - m_n) >= 1 && (cyc - m_n) <= m_len + 2 &&
            !(m_who ? req1 : req0)) begin
          m_ab = cyc;
        end else if ((m_ab < 0 && cyc >= m_n + m_len + 4) ||
                     (m_ab >= 0 && cyc >= m_ab + 2)) begin
          m_act  = 1'b0;
          m_last = m_who;
        end
      end
      if (!m_act && (req0 || req1)) begin
        m_who = (req0 && req1) ? !m_last : req1;
        m_len = m_who ? int'(len1) : int'(len0);
        m_n   = cyc;
        m_ab  = -1;
        m_act = 1'b1;
      end
    end

    @(negedge clk);
    c = cyc + 1;
    k = c - m_n;
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_busy = 0; e_t = 0; e_clr = 0;
    q_chk = 1'b0; q_exp = 0;
    if (!clr && m_act) begin
      if (m_ab >= 0 && c == m_ab + 1) begin
        e_busy = 1; e_clr = 1; q_chk = 1'b1; q_exp = 0;
      end else if (m_ab < 0 || c <= m_ab) begin
        if (k >= 1 && k <= m_len + 3) begin
          if (m_who) e_g1 = 1; else e_g0 = 1;
          e_busy = 1;
          q_chk  = 1'b1;
          q_exp  = (k <= 2) ? 0 : (((k - 2) < m_len) ? k - 2 : m_len);
        end
        e_clr = (k == 1) ? 1 : 0;
        e_t   = (k >= 2 && k <= m_len + 1) ? 1 : 0;
        if (k == m_len + 3) begin
          if (m_who) e_d1 = 1; else e_d0 = 1;
        end
      end
    end
    chk("gnt0", int'(gnt0), e_g0);
    chk("gnt1", int'(gnt1), e_g1);
    chk("done0", int'(done0), e_d0);
    chk("done1", int'(done1), e_d1);
    chk("busy", int'(busy), e_busy);
    chk("cnt_t", int'(cnt_t), e_t);
    chk("cnt_clr", int'(cnt_clr), e_clr);
    chk("gnt_excl", int'(gnt0 & gnt1), 0);
    if (q_chk) chk("cnt_q", int'(cnt_q), q_exp);

    if (gnt0 && !pg0) begin order.push_back(0); if (fg0 == 0) fg0 = c; end
    if (gnt1 && !pg1) begin order.push_back(1); if (fg1 == 0) fg1 = c; end
    if (gnt0) lg0 = c;
    if (gnt1) lg1 = c;
    pg0 = gnt0;
    pg1 = gnt1;
    if (cnt_t) tcnt++;
    if (done0) begin nd++; if (fd0 == 0) fd0 = c; q_done = int'(cnt_q); end
    if (done1) begin nd++; if (fd1 == 0) fd1 = c; q_done = int'(cnt_q); end
  endtask

  task automatic wait_dones(input int target, input int budget, input string nm);
    for (int i = 0; i < budget && nd < target; i++) tick();
    chk(nm, int'(nd >= target), 1);
  endtask

  task automatic wait_grants(input int target, input int budget, input string nm);
    for (int i = 0; i < budget && order.size() < target; i++) tick();
    chk(nm, int'(order.size() >= target), 1);
  endtask

  int n;
  int exp_order[4];

  initial begin
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = 8'd0; len1 = 8'd0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    clear_rec();
    repeat (2) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'({gnt1, gnt0}), 0);
    clr = 1'b0;
    tick();

    // Single request, len 5
    req0 = 1'b1; len0 = 8'd5; n = cyc + 1; clear_rec();
    wait_dones(1, 20, "t1_timeout");
    req0 = 1'b0;
    tick();
    chk("t1_gnt_first", fg0, n + 1);
    chk("t1_gnt_last", lg0, n + 8);
    chk("t1_tcnt", tcnt, 5);
    chk("t1_done", fd0, n + 8);
    chk("t1_q", q_done, 5);

    // Zero length on requester 1
    tick();
    req1 = 1'b1; len1 = 8'd0; n = cyc + 1; clear_rec();
    wait_dones(1, 10, "t2_timeout");
    req1 = 1'b0;
    tick();
    chk("t2_tcnt", tcnt, 0);
    chk("t2_done", fd1, n + 3);
    chk("t2_gnt_first", fg1, n + 1);
    chk("t2_gnt_last", lg1, n + 3);

    // Contention straight after reset
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req0 = 1'b1; req1 = 1'b1; len0 = 8'd2; len1 = 8'd3; n = cyc + 1; clear_rec();
    wait_dones(4, 60, "t3_timeout");
    req0 = 1'b0; req1 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      chk("t3_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    chk("t3_done0", fd0, n + 5);
    chk("t3_gnt1", fg1, n + 7);

    // Maximum length
    tick();
    req0 = 1'b1; len0 = 8'd255; n = cyc + 1; clear_rec();
    wait_dones(1, 300, "t4_timeout");
    req0 = 1'b0;
    tick();
    chk("t4_tcnt", tcnt, 255);
    chk("t4_done", fd0, n + 258);
    chk("t4_q", q_done, 255);

    // Abort three cycles into RUN with requester 1 pending
    tick();
    req0 = 1'b1; len0 = 8'd10; n = cyc + 1; clear_rec();
    tick();
    req1 = 1'b1; len1 = 8'd20;
    repeat (3) tick();
    req0 = 1'b0;
    tick();
    chk("t5_abort_gnt0", int'(gnt0), 0);
    chk("t5_abort_clr", int'(cnt_clr), 1);
    wait_grants(2, 10, "t5_timeout");
    chk("t5_no_done0", fd0, 0);
    chk("t5_gnt0_last", lg0, n + 4);
    chk("t5_gnt1", fg1, n + 7);

    // Reset in the middle of requester 1's run
    repeat (5) tick();
    #2 clr = 1'b1;
    #1;
    chk("t6_async_gnt1", int'(gnt1), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_t", int'(cnt_t), 0);
    chk("t6_async_clr", int'(cnt_clr), 0);
    req0 = 1'b1; len0 = 8'd2;
    repeat (2) tick();
    clr = 1'b0; n = cyc + 1; clear_rec();
    wait_grants(1, 5, "t6_timeout");
    chk("t6_first", (order.size() > 0) ? order[0] : -1, 0);
    chk("t6_gnt0", fg0, n + 1);
    wait_dones(1, 20, "t6_done0_timeout");
    req0 = 1'b0;
    wait_dones(2, 40, "t6_done1_timeout");
    req1 = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
